sipo_deser: RTL
===============

SIPO_DESER -- requirements
Module: sipo_deser

Interface
REQ-001 Parameter WIDTH, default 4, word width in bits; legal range 2..16.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 s_in  input  1  serial data bit, LSB of each word first.
REQ-005 s_valid  input  1  s_in qualifier; a bit is sampled only on edges where s_valid=1.
REQ-006 sync  input  1  word-start marker; meaningful only with s_valid=1.
REQ-007 p_ready  input  1  downstream accepts the head word.
REQ-008 clr_ovf  input  1  clears the sticky overflow flag.
REQ-009 p_out  output  WIDTH  head word of the output buffer.
REQ-010 p_valid  output  1  p_out holds a valid word.
REQ-011 fill  output  2  number of buffered words, 0..2.
REQ-012 overflow  output  1  sticky; a completed word was dropped.

Function
REQ-013 Two FSM states, HUNT and SHIFT, plus a bit counter bit_cnt of 0..WIDTH-1.
REQ-014 HUNT: s_valid=1 with sync=0 -> bit ignored, stay HUNT; s_valid=1 with sync=1 -> bit taken as bit 0, bit_cnt=1, go SHIFT.
REQ-015 SHIFT: each sampled bit shifts into the shift register at the MSB end, shifting right; after WIDTH bits, word bit k = k-th bit sampled.
REQ-016 SHIFT, s_valid=1, sync=0, bit_cnt=WIDTH-1: word completes, including the current s_in; push it to the buffer on the same edge; bit_cnt wraps to 0; stay SHIFT.
REQ-017 SHIFT, s_valid=1, sync=1: partial word discarded, current bit becomes bit 0, bit_cnt=1; no push, even if bit_cnt was WIDTH-1.
REQ-018 s_valid=0: shift register, bit_cnt and state hold, regardless of sync and s_in.
REQ-019 Output buffer: 2-entry FIFO; p_out = oldest entry; p_valid = (fill!=0), both driven from registers.
REQ-020 Pop on an edge where p_valid=1 and p_ready=1; p_out holds stable while p_valid=1 and p_ready=0.
REQ-021 Latency: a word completing at edge N appears on p_out/p_valid after edge N when the buffer was empty, or when fill=1 and a pop occurs at edge N.
REQ-022 Push with fill<2: stored; fill+1, or unchanged if a pop also occurs.
REQ-023 Push with fill=2 and a pop on the same edge: accepted; fill stays 2.
REQ-024 Push with fill=2 and no pop: word dropped, buffer unchanged, overflow set to 1.
REQ-025 overflow stays 1 until clr_ovf=1 on an edge; if a set and clr_ovf occur on the same edge, set wins.
REQ-026 p_ready with p_valid=0: no effect.

Reset
REQ-027 rst_n=0 immediately, independent of clk: state=HUNT, bit_cnt=0, shift register=0, buffer emptied, p_out=0, p_valid=0, fill=0, overflow=0.
REQ-028 Reset mid-word or with a full buffer: all partial and buffered data lost; after release, the block needs a new sync to leave HUNT.
REQ-029 rst_n release is synchronous to the first following clk edge; no sampling occurs on the release edge itself if rst_n is low at that edge.

Verification (WIDTH=4)
REQ-030 Reset, then s_valid pulses with bits 1,1,1,1 and sync=0 -> no push, p_valid=0, state HUNT.
REQ-031 sync+bit 0, then bits 1,0,1 (stream 0,1,0,1), p_ready=0 -> after the 4th bit edge p_valid=1, p_out=4'hA, fill=1; p_ready=1 for one cycle -> p_valid=0.
REQ-032 p_ready=0, three back-to-back words 4'h3, 4'hC, 4'h5 -> fill=2, p_out=4'h3, overflow=1, 4'h5 lost; pops yield 4'h3 then 4'hC; clr_ovf -> overflow=0.
REQ-033 fill=2, 4th bit of a new word on the same edge as a pop -> fill stays 2, new word queued behind the remaining entry, overflow unchanged.
REQ-034 Two bits of a word, then sync+bit 1 followed by bits 0,0,1 -> partial discarded; single word 4'h9 delivered.
REQ-035 rst_n low for 1 cycle mid-word with fill=1 -> all outputs zero at once; following bits without sync are ignored.

Source files
------------

// File: rtl/sipo_deser.sv
// sipo_deser: serial-in / parallel-out deserializer.
// Hunts for a sync-marked start bit, assembles WIDTH-bit words LSB first,
// and queues completed words in a 2-entry output FIFO with a sticky
// overflow flag for words dropped while the FIFO is full.
module sipo_deser #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_in,
  input  logic             s_valid,
  input  logic             sync,
  input  logic             p_ready,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] p_out,
  output logic             p_valid,
  output logic [1:0]       fill,
  output logic             overflow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {HUNT = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state_reg;
  logic [CW-1:0]    bit_cnt_reg;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] head_reg;
  logic [WIDTH-1:0] tail_reg;
  logic [1:0]       fill_reg;
  logic             p_valid_reg;
  logic             overflow_reg;

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] word_done;
  logic [1:0]       fill_next;

  // Completion detect, pop qualification and next FIFO occupancy.
  always_comb begin
    word_done = {s_in, shift_reg[WIDTH-1:1]};
    push      = (state_reg == SHIFT) && s_valid && !sync && (bit_cnt_reg == LAST_BIT);
    pop       = p_valid_reg && p_ready;
    fill_next = fill_reg;
    if (push && !pop && fill_reg != 2'd2)
      fill_next = fill_reg + 2'd1;
    else if (!push && pop)
      fill_next = fill_reg - 2'd1;
  end

  // Framing FSM: hunt for sync, then shift bits in at the MSB end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= HUNT;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
    end else if (s_valid) begin
      if (sync) begin
        // A sync always restarts framing; any partial word is abandoned.
        state_reg   <= SHIFT;
        bit_cnt_reg <= CW'(1);
        shift_reg   <= {s_in, {(WIDTH-1){1'b0}}};
      end else if (state_reg == SHIFT) begin
        shift_reg   <= word_done;
        bit_cnt_reg <= (bit_cnt_reg == LAST_BIT) ? '0 : bit_cnt_reg + CW'(1);
      end
    end
  end

  // Two-entry output FIFO; head_reg is the word presented on p_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg    <= '0;
      tail_reg    <= '0;
      fill_reg    <= 2'd0;
      p_valid_reg <= 1'b0;
    end else begin
      case (fill_reg)
        2'd0: begin
          if (push) head_reg <= word_done;
        end
        2'd1: begin
          if (push && pop) head_reg <= word_done;
          else if (push)   tail_reg <= word_done;
        end
        default: begin
          // Full: a push is only accepted when the head leaves on the same edge.
          if (pop) begin
            head_reg <= tail_reg;
            if (push) tail_reg <= word_done;
          end
        end
      endcase
      fill_reg    <= fill_next;
      p_valid_reg <= (fill_next != 2'd0);
    end
  end

  // Sticky overflow: a drop on the same edge as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      overflow_reg <= 1'b0;
    else if (push && !pop && fill_reg == 2'd2)
      overflow_reg <= 1'b1;
    else if (clr_ovf)
      overflow_reg <= 1'b0;
  end

  assign p_out    = head_reg;
  assign p_valid  = p_valid_reg;
  assign fill     = fill_reg;
  assign overflow = overflow_reg;

endmodule
